// File: rtl/handshake_pkg.sv
// Shared constants and helpers for the handshake channel blocks.
package handshake_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // Never returns 0, so a DEPTH of 1 still gets a 1-bit pointer.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/handshake_fifo_ptr.sv
// Wrap-around slot pointer: counts 0..DEPTH-1 and returns to 0, any DEPTH >= 1.
module handshake_fifo_ptr
    import handshake_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = clog2_safe(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;
    logic             w_at_last;

    // Explicit compare against DEPTH-1 rather than relying on natural overflow.
    assign w_at_last = (r_ptr == PTR_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= w_at_last ? '0 : r_ptr + PTR_W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/handshake_fifo_elastic.sv
// Registered elastic FIFO that decouples valid/ready between the constant stages and their consumer.
module handshake_fifo_elastic
    import handshake_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = 4,
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int PTR_W = clog2_safe(DEPTH);

    if (DEPTH < 1 || DEPTH > 256) begin : g_depth_check
        $error("handshake_fifo_elastic: DEPTH must be in 1..256");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_WIDTH-1:0]  r_count;
    logic [PTR_W-1:0]      w_wr_ptr;
    logic [PTR_W-1:0]      w_rd_ptr;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;

    // Handshake flags come only from r_count, so no input reaches an output combinationally.
    assign w_full  = (r_count == CNT_WIDTH'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = ins_valid && !w_full;
    assign w_pop   = outs_ready && !w_empty;

    handshake_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_push),
        .o_ptr (w_wr_ptr)
    );

    handshake_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_pop),
        .o_ptr (w_rd_ptr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[w_wr_ptr] <= ins;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_WIDTH'(1);
        end
    end

    assign ins_ready  = !w_full;
    assign outs_valid = !w_empty;
    assign outs       = r_mem[w_rd_ptr];
    assign count      = r_count;

endmodule

// File: tb/tb_handshake_fifo_elastic.sv
// Scoreboard bench: DEPTH=4 instance for fill/drain/full/reset, DEPTH=3 instance for wrap streaming.
module tb_handshake_fifo_elastic;

    localparam int DW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b0;

    logic [DW-1:0] a_ins = '0;
    logic          a_ins_valid = 1'b0;
    logic          a_ins_ready;
    logic [DW-1:0] a_outs;
    logic          a_outs_valid;
    logic          a_outs_ready = 1'b0;
    logic [2:0]    a_count;

    logic [DW-1:0] b_ins = '0;
    logic          b_ins_valid = 1'b0;
    logic          b_ins_ready;
    logic [DW-1:0] b_outs;
    logic          b_outs_valid;
    logic          b_outs_ready = 1'b0;
    logic [1:0]    b_count;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] q_a[$];
    logic [DW-1:0] q_b[$];

    always #5 clk = ~clk;

    handshake_fifo_elastic #(.DATA_WIDTH(DW), .DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .ins(a_ins), .ins_valid(a_ins_valid), .ins_ready(a_ins_ready),
        .outs(a_outs), .outs_valid(a_outs_valid), .outs_ready(a_outs_ready), .count(a_count)
    );

    handshake_fifo_elastic #(.DATA_WIDTH(DW), .DEPTH(3)) u_b (
        .clk(clk), .rst(rst), .ins(b_ins), .ins_valid(b_ins_valid), .ins_ready(b_ins_ready),
        .outs(b_outs), .outs_valid(b_outs_valid), .outs_ready(b_outs_ready), .count(b_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present a token on A and hold it until accepted; the expected output is queued on acceptance.
    task automatic put_a(input logic [DW-1:0] v);
        bit ok = 0;
        a_ins = v;
        a_ins_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (a_ins_ready) begin
                q_a.push_back(v);
                ok = 1;
            end
        end
        if (!ok) chk("a_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic put_b(input logic [DW-1:0] v);
        bit ok = 0;
        b_ins = v;
        b_ins_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (b_ins_ready) begin
                q_b.push_back(v);
                ok = 1;
            end
        end
        if (!ok) chk("b_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    // Monitors: a pop happens at the next rising edge whenever valid && ready is seen here.
    logic          a_stall = 1'b0, b_stall = 1'b0;
    logic [DW-1:0] a_hold, b_hold;

    always @(negedge clk) begin
        if (!rst) begin
            a_stall = 1'b0;
        end else begin
            if (a_stall) begin
                chk("a_hold_valid", 32'(a_outs_valid), 32'd1);
                chk("a_hold_data", 32'(a_outs), 32'(a_hold));
            end
            if (a_outs_valid && a_outs_ready) begin
                if (q_a.size() == 0) chk("a_unexpected_token", 32'(a_outs), 32'h1FFFFFFF);
                else chk("a_pop_data", 32'(a_outs), 32'(q_a.pop_front()));
            end
            a_stall = a_outs_valid && !a_outs_ready;
            a_hold  = a_outs;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            b_stall = 1'b0;
        end else begin
            if (b_stall) begin
                chk("b_hold_valid", 32'(b_outs_valid), 32'd1);
                chk("b_hold_data", 32'(b_outs), 32'(b_hold));
            end
            if (b_outs_valid && b_outs_ready) begin
                if (q_b.size() == 0) chk("b_unexpected_token", 32'(b_outs), 32'h1FFFFFFF);
                else chk("b_pop_data", 32'(b_outs), 32'(q_b.pop_front()));
            end
            b_stall = b_outs_valid && !b_outs_ready;
            b_hold  = b_outs;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset then idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs_valid", 32'(a_outs_valid), 32'd0);
            chk("idle_ins_ready", 32'(a_ins_ready), 32'd1);
            chk("idle_count", 32'(a_count), 32'd0);
            chk("idle_outs", 32'(a_outs), 32'd0);
        end
        chk("idle_b_outs_valid", 32'(b_outs_valid), 32'd0);
        chk("idle_b_count", 32'(b_count), 32'd0);

        // 2: constant feed fills DEPTH=4
        @(posedge clk); #1;
        a_ins = 17'h1FBE7;
        a_ins_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            q_a.push_back(17'h1FBE7);
            @(posedge clk); #1;
            chk("fill_count", 32'(a_count), 32'(k));
            chk("fill_outs_valid", 32'(a_outs_valid), 32'd1);
            chk("fill_outs", 32'(a_outs), 32'h1FBE7);
        end
        chk("fill_ins_ready", 32'(a_ins_ready), 32'd0);
        a_ins_valid = 1'b0;

        // 3: drain from full
        a_outs_ready = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            @(posedge clk); #1;
            chk("drain_count", 32'(a_count), 32'(k));
            chk("drain_ins_ready", 32'(a_ins_ready), 32'd1);
        end
        chk("drain_outs_valid", 32'(a_outs_valid), 32'd0);
        chk("drain_queue_empty", 32'(q_a.size()), 32'd0);
        a_outs_ready = 1'b0;

        // 4: DEPTH=3 streaming 1..10 with wrap
        b_outs_ready = 1'b1;
        @(negedge clk);
        chk("stream_pre_valid", 32'(b_outs_valid), 32'd0);
        @(posedge clk); #1;
        for (int v = 1; v <= 10; v++) begin
            put_b(DW'(v));
            chk("stream_count", 32'(b_count), 32'd1);
            chk("stream_valid", 32'(b_outs_valid), 32'd1);
            chk("stream_outs", 32'(b_outs), 32'(v));
        end
        b_ins_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream_end_count", 32'(b_count), 32'd0);
        chk("stream_queue_empty", 32'(q_b.size()), 32'd0);

        // 5: full with outs_ready asserted: pop but no push that cycle
        put_a(17'h000A1);
        put_a(17'h000B2);
        put_a(17'h000C3);
        put_a(17'h000D4);
        chk("full_count", 32'(a_count), 32'd4);
        a_ins = 17'h000E5;
        a_ins_valid = 1'b1;
        a_outs_ready = 1'b1;
        @(negedge clk);
        chk("full_no_bypass", 32'(a_ins_ready), 32'd0);
        chk("full_head", 32'(a_outs), 32'h000A1);
        @(posedge clk); #1;
        chk("full_pop_count", 32'(a_count), 32'd3);
        chk("full_ready_again", 32'(a_ins_ready), 32'd1);
        put_a(17'h000E5);
        a_ins_valid = 1'b0;
        for (int n = 0; n < 20 && q_a.size() != 0; n++) @(posedge clk);
        #1;
        chk("order_queue_empty", 32'(q_a.size()), 32'd0);
        chk("order_count", 32'(a_count), 32'd0);
        a_outs_ready = 1'b0;

        // 6: reset mid-stream drops tokens asynchronously
        put_a(17'h00011);
        put_a(17'h00022);
        a_ins_valid = 1'b0;
        chk("mid_count", 32'(a_count), 32'd2);
        #3 rst = 1'b0;
        #1;
        chk("rst_async_valid", 32'(a_outs_valid), 32'd0);
        chk("rst_async_count", 32'(a_count), 32'd0);
        q_a.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        a_outs_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(a_outs_valid), 32'd0);
            chk("post_rst_count", 32'(a_count), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
